sky130_sram_1rw1r_param: RTL and testbench
==========================================

SKY130_SRAM_1RW1R_PARAM -- requirements
Module: sky130_sram_1rw1r_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
REQ-003 Parameter NUM_WMASKS, default 4, write-mask lanes; DATA_WIDTH SHALL be an exact multiple of NUM_WMASKS, lane width = DATA_WIDTH/NUM_WMASKS.
REQ-004 Parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from request sample to dout valid.
REQ-005 Parameter CLEAR_ON_RESET, default 1, 1 = zero-fill the array after reset.
REQ-006 clk0  input  1  single clock; all ports and logic are synchronous to its rising edge.
REQ-007 rst0  input  1  synchronous, active-high reset.
REQ-008 csb0  input  1  port 0 active-low chip select.
REQ-009 web0  input  1  port 0 active-low write enable.
REQ-010 wmask0  input  NUM_WMASKS  port 0 lane write mask, bit i enables lane i.
REQ-011 addr0  input  ADDR_WIDTH  port 0 address.
REQ-012 din0  input  DATA_WIDTH  port 0 write data.
REQ-013 dout0  output  DATA_WIDTH  port 0 read data.
REQ-014 dout0_valid  output  1  one-cycle pulse, dout0 carries new read data.
REQ-015 csb1  input  1  port 1 (read-only) active-low chip select.
REQ-016 addr1  input  ADDR_WIDTH  port 1 address.
REQ-017 dout1  output  DATA_WIDTH  port 1 read data.
REQ-018 dout1_valid  output  1  one-cycle pulse, dout1 carries new read data.
REQ-019 busy  output  1  high while the array is being cleared; requests ignored.
REQ-020 coll_cnt  output  16  saturating count of same-address write/read collisions.

Function
REQ-021 States: INIT (clearing), READY; requests are sampled only in READY.
REQ-022 Port 0 write (csb0=0, web0=0) sampled at edge N commits masked lanes at edge N; unmasked lanes unchanged; wmask0=0 writes nothing; no dout0_valid.
REQ-023 Port 0 read (csb0=0, web0=1) sampled at edge N drives dout0 with dout0_valid=1 after edge N+READ_LATENCY, for exactly one cycle.
REQ-024 Port 1 read (csb1=0) sampled at edge N behaves identically on dout1/dout1_valid.
REQ-025 dout0/dout1 hold their last read value when no read completes; never driven X by the block.
REQ-026 Back-to-back reads every cycle are accepted; throughput one read per port per cycle.
REQ-027 Collision = port 0 write and port 1 read sampled at the same edge with addr0 == addr1; each increments coll_cnt by 1, holding at 16'hFFFF.
REQ-028 Port 0 read plus port 1 read to the same address both return the stored word; not a collision.
REQ-029 In INIT one word per cycle is written to zero at an incrementing pointer from 0; after word RAM_DEPTH-1 the state becomes READY at the next edge; busy=1 throughout INIT.
REQ-030 Requests presented while busy=1 are dropped: no write, no valid pulse, no collision count.

Reset
REQ-031 rst0=1 at an edge: dout0, dout1 = 0; dout0_valid, dout1_valid = 0; coll_cnt = 0; in-flight reads discarded; clear pointer = 0.
REQ-032 CLEAR_ON_RESET=1: state = INIT, busy=1 from the edge rst0 is sampled high; reset during INIT restarts the clear at address 0.
REQ-033 CLEAR_ON_RESET=0: state = READY, busy=0; array contents are not modified by reset.

Configuration
REQ-034 Macro SKY130_SRAM_BYPASS_EN defined: on a collision dout1 returns the post-write word (masked lanes from din0, other lanes from the array).
REQ-035 Macro SKY130_SRAM_BYPASS_EN undefined: on a collision dout1 returns the pre-write word; coll_cnt behaviour identical in both builds.

Verification
REQ-036 Reset with CLEAR_ON_RESET=1, depth 1024 -> busy high exactly 1024 cycles; then read any address returns 0.
REQ-037 Write addr0=0x005 din0=0xDEADBEEF wmask0=4'b0101 over 0 -> read port 1 at 0x005 returns 0x00AD00EF, valid READ_LATENCY cycles later (test latencies 1 and 2).
REQ-038 Same edge: port 0 writes 0x11223344 full mask to 0x010 (old 0xAAAAAAAA), port 1 reads 0x010 -> dout1 = 0x11223344 with BYPASS_EN, 0xAAAAAAAA without; coll_cnt = 1.
REQ-039 Port 1 read every cycle addresses 0..7, port 0 reads 7..0 -> eight consecutive valid pulses per port, data in order.
REQ-040 Assert rst0 at clear pointer 500 -> busy stays high, clear restarts, 1024 further busy cycles; reset mid-read -> no valid pulse emitted.
REQ-041 Force 65540 collisions -> coll_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/sky130_sram_1rw1r_param_if.sv
// Port bundle for the 1RW+1R SRAM: port 0 read/write, port 1 read-only, plus status.
// The master drives requests; the slave (the SRAM) returns read data, valid pulses and status.
interface sky130_sram_1rw1r_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 4
);
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dout0_valid;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;
    logic                  busy;
    logic [15:0]           coll_cnt;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, dout0_valid, dout1, dout1_valid, busy, coll_cnt
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, dout0_valid, dout1, dout1_valid, busy, coll_cnt
    );
endinterface

// File: rtl/sky130_sram_1rw1r_param.sv
// 1RW+1R SRAM with lane masks, READ_LATENCY (1|2) read pipeline and optional zero-fill after reset.
// No backpressure: requests are dropped while busy. SKY130_SRAM_BYPASS_EN forwards port-0 write data to port 1 on collisions.
module sky130_sram_1rw1r_param #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int NUM_WMASKS     = 4,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic clk0,
    input  logic rst0,
    sky130_sram_1rw1r_param_if.slave bus
);
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int LANE_W    = DATA_WIDTH / NUM_WMASKS;

    typedef enum logic {INIT, READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  ready, rd0, wr0, rd1, coll;
    logic [DATA_WIDTH-1:0] rdata0, rdata1, rdata1_sel;
    logic                  v0_s1, v1_s1;
    logic [DATA_WIDTH-1:0] d0_s1, d1_s1;
    logic [15:0]           coll_cnt_q;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? INIT : READY;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == INIT) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (&clr_ptr_q) state_d = READY;
        end
    end

    assign ready = (state_q == READY);
    assign rd0   = ready & ~bus.csb0 & bus.web0;
    assign wr0   = ready & ~bus.csb0 & ~bus.web0;
    assign rd1   = ready & ~bus.csb1;
    assign coll  = wr0 & rd1 & (bus.addr0 == bus.addr1);

    always_ff @(posedge clk0) begin
        if (!rst0) begin
            if (state_q == INIT) begin
                mem[clr_ptr_q] <= '0;
            end else if (wr0) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (bus.wmask0[i])
                        mem[bus.addr0][i*LANE_W +: LANE_W] <= bus.din0[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Array reads see the pre-write word; same-edge writes land via non-blocking update.
    assign rdata0 = mem[bus.addr0];
    assign rdata1 = mem[bus.addr1];

`ifdef SKY130_SRAM_BYPASS_EN
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        merged = rdata1;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (bus.wmask0[i]) merged[i*LANE_W +: LANE_W] = bus.din0[i*LANE_W +: LANE_W];
        end
    end

    assign rdata1_sel = coll ? merged : rdata1;
`else
    assign rdata1_sel = rdata1;
`endif

    always_ff @(posedge clk0) begin
        if (rst0) begin
            v0_s1 <= 1'b0;
            v1_s1 <= 1'b0;
            d0_s1 <= '0;
            d1_s1 <= '0;
        end else begin
            v0_s1 <= rd0;
            v1_s1 <= rd1;
            if (rd0) d0_s1 <= rdata0;
            if (rd1) d1_s1 <= rdata1_sel;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  v0_s2, v1_s2;
            logic [DATA_WIDTH-1:0] d0_s2, d1_s2;

            always_ff @(posedge clk0) begin
                if (rst0) begin
                    v0_s2 <= 1'b0;
                    v1_s2 <= 1'b0;
                    d0_s2 <= '0;
                    d1_s2 <= '0;
                end else begin
                    v0_s2 <= v0_s1;
                    v1_s2 <= v1_s1;
                    if (v0_s1) d0_s2 <= d0_s1;
                    if (v1_s1) d1_s2 <= d1_s1;
                end
            end

            assign bus.dout0       = d0_s2;
            assign bus.dout0_valid = v0_s2;
            assign bus.dout1       = d1_s2;
            assign bus.dout1_valid = v1_s2;
        end else begin : g_lat1
            assign bus.dout0       = d0_s1;
            assign bus.dout0_valid = v0_s1;
            assign bus.dout1       = d1_s1;
            assign bus.dout1_valid = v1_s1;
        end
    endgenerate

    always_ff @(posedge clk0) begin
        if (rst0) begin
            coll_cnt_q <= '0;
        end else if (coll && (coll_cnt_q != 16'hFFFF)) begin
            coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end

    assign bus.coll_cnt = coll_cnt_q;
    assign bus.busy     = (state_q == INIT);
endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
// Bench: dut_a (latency 1, clear on reset) runs the vector table and long sequences; dut_b (latency 2, no clear) the pipeline cases.
module tb_sky130_sram_1rw1r_param;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sky130_sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_WMASKS(4)) ba ();
    sky130_sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_WMASKS(4)) bb ();

    sky130_sram_1rw1r_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_WMASKS(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut_a (.clk0(clk), .rst0(rst_a), .bus(ba));

    sky130_sram_1rw1r_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_WMASKS(4), .READ_LATENCY(2), .CLEAR_ON_RESET(0)
    ) dut_b (.clk0(clk), .rst0(rst_b), .bus(bb));

`ifdef SKY130_SRAM_BYPASS_EN
    localparam logic [31:0] COLL1 = 32'h11223344;
    localparam logic [31:0] COLL2 = 32'h12000000;
`else
    localparam logic [31:0] COLL1 = 32'hAAAAAAAA;
    localparam logic [31:0] COLL2 = 32'h00000000;
`endif

    typedef struct {
        logic        csb0;
        logic        web0;
        logic [3:0]  wmask0;
        logic [9:0]  addr0;
        logic [31:0] din0;
        logic        csb1;
        logic [9:0]  addr1;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic [15:0] coll;
    } vec_t;

    vec_t vt [12];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_a(input logic c0, input logic w0, input logic [3:0] m, input logic [9:0] a0,
                         input logic [31:0] d, input logic c1, input logic [9:0] a1);
        ba.csb0 = c0; ba.web0 = w0; ba.wmask0 = m; ba.addr0 = a0; ba.din0 = d;
        ba.csb1 = c1; ba.addr1 = a1;
    endtask

    task automatic set_b(input logic c0, input logic w0, input logic [3:0] m, input logic [9:0] a0,
                         input logic [31:0] d, input logic c1, input logic [9:0] a1);
        bb.csb0 = c0; bb.web0 = w0; bb.wmask0 = m; bb.addr0 = a0; bb.din0 = d;
        bb.csb1 = c1; bb.addr1 = a1;
    endtask

    // Counts cycles with busy high (bounded) and any valid/collision activity seen meanwhile.
    task automatic count_busy(output int n, output int spurious);
        n = 0;
        spurious = 0;
        for (int i = 0; i < 3000 && ba.busy === 1'b1; i++) begin
            if (ba.dout0_valid !== 1'b0 || ba.dout1_valid !== 1'b0 || ba.coll_cnt !== 16'h0)
                spurious++;
            n++;
            tick();
        end
        set_a(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);
    endtask

    initial begin
        int nb, sp, pulses0, pulses1;

        vt[0]  = '{1'b0, 1'b0, 4'b0101, 10'h005, 32'hDEADBEEF, 1'b1, 10'h000, 1'b0, 32'h0,        1'b0, 32'h0,        16'd0};
        vt[1]  = '{1'b1, 1'b1, 4'b0000, 10'h000, 32'h0,        1'b0, 10'h005, 1'b0, 32'h0,        1'b1, 32'h00AD00EF, 16'd0};
        vt[2]  = '{1'b0, 1'b0, 4'b1111, 10'h010, 32'hAAAAAAAA, 1'b1, 10'h000, 1'b0, 32'h0,        1'b0, 32'h00AD00EF, 16'd0};
        vt[3]  = '{1'b0, 1'b0, 4'b1111, 10'h010, 32'h11223344, 1'b0, 10'h010, 1'b0, 32'h0,        1'b1, COLL1,        16'd1};
        vt[4]  = '{1'b0, 1'b1, 4'b0000, 10'h010, 32'h0,        1'b0, 10'h010, 1'b1, 32'h11223344, 1'b1, 32'h11223344, 16'd1};
        vt[5]  = '{1'b0, 1'b0, 4'b0000, 10'h005, 32'hFFFFFFFF, 1'b1, 10'h005, 1'b0, 32'h11223344, 1'b0, 32'h11223344, 16'd1};
        vt[6]  = '{1'b0, 1'b1, 4'b0000, 10'h005, 32'h0,        1'b0, 10'h003, 1'b1, 32'h00AD00EF, 1'b1, 32'h0,        16'd1};
        vt[7]  = '{1'b1, 1'b1, 4'b0000, 10'h000, 32'h0,        1'b1, 10'h000, 1'b0, 32'h00AD00EF, 1'b0, 32'h0,        16'd1};
        vt[8]  = '{1'b1, 1'b0, 4'b1111, 10'h005, 32'h0,        1'b1, 10'h005, 1'b0, 32'h00AD00EF, 1'b0, 32'h0,        16'd1};
        vt[9]  = '{1'b0, 1'b1, 4'b0000, 10'h005, 32'h0,        1'b0, 10'h3FF, 1'b1, 32'h00AD00EF, 1'b1, 32'h0,        16'd1};
        vt[10] = '{1'b0, 1'b0, 4'b1000, 10'h3FF, 32'h12345678, 1'b0, 10'h3FF, 1'b0, 32'h00AD00EF, 1'b1, COLL2,        16'd2};
        vt[11] = '{1'b0, 1'b1, 4'b0000, 10'h3FF, 32'h0,        1'b0, 10'h010, 1'b1, 32'h12000000, 1'b1, 32'h11223344, 16'd2};

        set_a(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);
        set_b(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        chk("a_rst_busy", 32'(ba.busy), 32'd1);
        chk("a_rst_dout0", ba.dout0, 32'h0);
        chk("a_rst_dout1", ba.dout1, 32'h0);
        chk("a_rst_valid", {30'd0, ba.dout0_valid, ba.dout1_valid}, 32'h0);
        chk("a_rst_coll", 32'(ba.coll_cnt), 32'h0);
        chk("b_rst_busy", 32'(bb.busy), 32'd0);
        chk("b_rst_dout1", bb.dout1, 32'h0);

        // Latency-2 instance, no clear: seed words explicitly.
        rst_b = 1'b0;
        set_b(1'b0, 1'b0, 4'hF, 10'h005, 32'h0, 1'b1, 10'h0);        tick();
        set_b(1'b0, 1'b0, 4'b0101, 10'h005, 32'hDEADBEEF, 1'b1, 10'h0); tick();
        set_b(1'b0, 1'b0, 4'hF, 10'h006, 32'h0000BEEF, 1'b1, 10'h0);  tick();
        chk("b_wr_novalid", {30'd0, bb.dout0_valid, bb.dout1_valid}, 32'h0);
        set_b(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b0, 10'h005);         tick();
        chk("b_rd1_lat_n1", 32'(bb.dout1_valid), 32'd0);
        set_b(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);           tick();
        chk("b_rd1_lat_v", 32'(bb.dout1_valid), 32'd1);
        chk("b_rd1_lat_d", bb.dout1, 32'h00AD00EF);
        tick();
        chk("b_rd1_pulse_end", 32'(bb.dout1_valid), 32'd0);
        chk("b_rd1_hold", bb.dout1, 32'h00AD00EF);
        set_b(1'b0, 1'b1, 4'h0, 10'h005, 32'h0, 1'b1, 10'h0);         tick();
        chk("b_rd0_n1", 32'(bb.dout0_valid), 32'd0);
        set_b(1'b0, 1'b1, 4'h0, 10'h006, 32'h0, 1'b1, 10'h0);         tick();
        chk("b_rd0_first", {bb.dout0[30:0], bb.dout0_valid}, {31'h00AD00EF, 1'b1});
        set_b(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);           tick();
        chk("b_rd0_second", {bb.dout0[30:0], bb.dout0_valid}, {31'h0000BEEF, 1'b1});
        tick();
        chk("b_rd0_end", 32'(bb.dout0_valid), 32'd0);
        set_b(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b0, 10'h006);         tick();
        set_b(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);
        rst_b = 1'b1;                                                  tick();
        chk("b_midrd_rst_v", 32'(bb.dout1_valid), 32'd0);
        chk("b_midrd_rst_d", bb.dout1, 32'h0);
        rst_b = 1'b0;                                                  tick();
        chk("b_midrd_after", 32'(bb.dout1_valid), 32'd0);
        set_b(1'b0, 1'b1, 4'h0, 10'h006, 32'h0, 1'b1, 10'h0);         tick();
        set_b(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);           tick();
        chk("b_keep_after_rst", {bb.dout0[30:0], bb.dout0_valid}, {31'h0000BEEF, 1'b1});

        // Latency-1 instance: clear after reset, then the vector table.
        rst_a = 1'b0;
        count_busy(nb, sp);
        chk("a_clear_cycles", 32'(nb), 32'd1024);
        for (int i = 0; i < 12; i++) begin
            set_a(vt[i].csb0, vt[i].web0, vt[i].wmask0, vt[i].addr0, vt[i].din0, vt[i].csb1, vt[i].addr1);
            tick();
            chk($sformatf("vec%0d_v0", i), 32'(ba.dout0_valid), 32'(vt[i].v0));
            chk($sformatf("vec%0d_d0", i), ba.dout0, vt[i].d0);
            chk($sformatf("vec%0d_v1", i), 32'(ba.dout1_valid), 32'(vt[i].v1));
            chk($sformatf("vec%0d_d1", i), ba.dout1, vt[i].d1);
            chk($sformatf("vec%0d_coll", i), 32'(ba.coll_cnt), 32'(vt[i].coll));
        end

        // Back-to-back reads on both ports.
        for (int i = 0; i < 8; i++) begin
            set_a(1'b0, 1'b0, 4'hF, 10'(i), 32'hC0DE0000 + 32'(i), 1'b1, 10'h0);
            tick();
        end
        pulses0 = 0;
        pulses1 = 0;
        for (int i = 0; i < 8; i++) begin
            set_a(1'b0, 1'b1, 4'h0, 10'(7 - i), 32'h0, 1'b0, 10'(i));
            tick();
            if (ba.dout0_valid === 1'b1) pulses0++;
            if (ba.dout1_valid === 1'b1) pulses1++;
            chk($sformatf("b2b_d0_%0d", i), ba.dout0, 32'hC0DE0000 + 32'(7 - i));
            chk($sformatf("b2b_d1_%0d", i), ba.dout1, 32'hC0DE0000 + 32'(i));
        end
        set_a(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);
        tick();
        chk("b2b_pulses0", 32'(pulses0), 32'd8);
        chk("b2b_pulses1", 32'(pulses1), 32'd8);
        chk("b2b_idle_valid", {30'd0, ba.dout0_valid, ba.dout1_valid}, 32'h0);

        // Saturating collision counter, starting from the table's two collisions.
        set_a(1'b0, 1'b0, 4'hF, 10'h000, 32'h0, 1'b0, 10'h000);
        for (int i = 0; i < 65540; i++) begin
            tick();
            if (i == 65531) chk("coll_near_sat", 32'(ba.coll_cnt), 32'h0000FFFE);
        end
        set_a(1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);
        tick();
        chk("coll_saturated", 32'(ba.coll_cnt), 32'h0000FFFF);

        // Reset in the middle of a clear; requests presented while busy must be dropped.
        rst_a = 1'b1; tick();
        rst_a = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        chk("midclr_busy", 32'(ba.busy), 32'd1);
        rst_a = 1'b1; tick();
        chk("midclr_rst_busy", 32'(ba.busy), 32'd1);
        chk("midclr_rst_coll", 32'(ba.coll_cnt), 32'h0);
        rst_a = 1'b0;
        set_a(1'b0, 1'b0, 4'hF, 10'h020, 32'h55555555, 1'b0, 10'h020);
        count_busy(nb, sp);
        chk("midclr_restart_cycles", 32'(nb), 32'd1024);
        chk("busy_drops_requests", 32'(sp), 32'd0);
        set_a(1'b0, 1'b1, 4'h0, 10'h020, 32'h0, 1'b0, 10'h010);
        tick();
        chk("after_clear_d0", ba.dout0, 32'h0);
        chk("after_clear_d1", ba.dout1, 32'h0);
        chk("after_clear_v", {30'd0, ba.dout0_valid, ba.dout1_valid}, 32'h3);
        chk("after_clear_coll", 32'(ba.coll_cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
